// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard receiver.
//   frame_state_e : frame FSM state encoding
//   CODE_EXT/BRK  : scan-code prefixes handled in the receiver
//   STAT_*        : bit positions inside the 32-bit status word
//   scan_word_t   : FIFO word {extended, break, code}
package ps2_pkg;

   typedef enum logic [1:0] {
      FS_IDLE   = 2'd0,
      FS_DATA   = 2'd1,
      FS_PARITY = 2'd2,
      FS_STOP   = 2'd3
   } frame_state_e;

   localparam logic [7:0] CODE_EXT = 8'hE0;
   localparam logic [7:0] CODE_BRK = 8'hF0;

   localparam int unsigned STAT_EMPTY   = 0;
   localparam int unsigned STAT_FULL    = 1;
   localparam int unsigned STAT_OVF     = 2;
   localparam int unsigned STAT_PERR    = 3;
   localparam int unsigned STAT_FERR    = 4;
   localparam int unsigned STAT_CNT_LSB = 8;
   localparam int unsigned STAT_CNT_W   = 8;

   localparam int unsigned SCAN_W = 10;

   typedef struct packed {
      logic       ext;
      logic [7:0] code;
      logic       brk;
   } scan_word_unused_t;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } scan_word_t;

   // True when the data bits plus the parity bit hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] code, input logic par);
      return ^{code, par};
   endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: synchronous FIFO with a registered head word.
//   clk, rst      : clock, asynchronous active-high reset
//   wr_en/wr_data : push request and word
//   rd_en         : pop strobe (ignored when empty)
//   head          : registered word at the FIFO head, 0 when empty
//   count         : occupancy 0..DEPTH
//   full, empty   : registered occupancy flags
//   ovf           : one-cycle pulse when a push was dropped
module ps2_rx_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     ovf
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
   logic             do_pop, do_push;

   // Pointer/count update; a pop on a full FIFO makes room for a same-cycle push.
   always_comb begin
      do_pop  = rd_en && !empty_q;
      do_push = wr_en && (!full_q || do_pop);
      wp_d    = do_push ? wp_q + AW'(1) : wp_q;
      rp_d    = do_pop  ? rp_q + AW'(1) : rp_q;
      cnt_d   = cnt_q;
      if (do_push && !do_pop)
         cnt_d = cnt_q + CW'(1);
      else if (do_pop && !do_push)
         cnt_d = cnt_q - CW'(1);
      full_d  = (cnt_d == CW'(DEPTH));
      empty_d = (cnt_d == '0);
      ovf_d   = wr_en && !do_push;
      // The new head is the incoming word when nothing else remains after the pop.
      if (empty_d)
         head_d = '0;
      else if (do_push && (empty_q || (do_pop && cnt_q == CW'(1))))
         head_d = wr_data;
      else
         head_d = mem_q[rp_d];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q    <= '0;
         rp_q    <= '0;
         cnt_q   <= '0;
         head_q  <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         ovf_q   <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         cnt_q   <= cnt_d;
         head_q  <= head_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         ovf_q   <= ovf_d;
         if (do_push)
            mem_q[wp_q] <= wr_data;
      end
   end

   assign head  = head_q;
   assign count = cnt_q;
   assign full  = full_q;
   assign empty = empty_q;
   assign ovf   = ovf_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver with scan-word FIFO.
//   clk, rst   : system clock, asynchronous active-high reset
//   ps2_c/d    : PS/2 clock and data, asynchronous to clk
//   fifo_rd    : pop strobe for the scan-word FIFO
//   status_clr : clears the sticky error/overflow flags
//   status     : {16'b0, count, 3'b0, frame_err, parity_err, overflow, full, empty}
//   data       : {22'b0, extended, break, code} of the FIFO head, 0 when empty
module ps2_kbd_rx
   import ps2_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned FILT_LEN    = 8,
   parameter int unsigned TIMEOUT_CYC = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ps2_c,
   input  logic        ps2_d,
   input  logic        fifo_rd,
   input  logic        status_clr,
   output logic [31:0] status,
   output logic [31:0] data
);

   localparam int unsigned FCW   = $clog2(FILT_LEN);
   localparam int unsigned TCW   = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic             c_meta_q, c_sync_q, d_meta_q, d_sync_q;
   logic             filt_q, filt_d;
   logic [FCW-1:0]   filt_cnt_q, filt_cnt_d;
   logic             smpl_en_q, smpl_en_d;
   frame_state_e     state_q, state_d;
   logic [7:0]       shift_q, shift_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic             par_ok_q, par_ok_d;
   logic [TCW-1:0]   to_cnt_q, to_cnt_d;
   logic             ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
   logic             wr_q, wr_d;
   scan_word_t       wr_word_q, wr_word_d;
   logic             ovf_q, ovf_d, perr_q, perr_d, ferr_q, ferr_d;
   logic             set_perr, set_ferr;

   logic [SCAN_W-1:0] fifo_head;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full, fifo_empty, fifo_ovf;

   // Glitch filter: the filtered clock follows only after FILT_LEN agreeing samples.
   always_comb begin
      filt_d     = filt_q;
      filt_cnt_d = '0;
      if (c_sync_q != filt_q) begin
         if (filt_cnt_q == FCW'(FILT_LEN - 1))
            filt_d = c_sync_q;
         else
            filt_cnt_d = filt_cnt_q + FCW'(1);
      end
      smpl_en_d = filt_q && !filt_d;
   end

   // Frame FSM, prefix tracking and timeout.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      par_ok_d   = par_ok_q;
      ext_pend_d = ext_pend_q;
      brk_pend_d = brk_pend_q;
      wr_d       = 1'b0;
      wr_word_d  = wr_word_q;
      set_perr   = 1'b0;
      set_ferr   = 1'b0;
      to_cnt_d   = (state_q == FS_IDLE || smpl_en_q) ? '0 : to_cnt_q + TCW'(1);

      if (smpl_en_q) begin
         case (state_q)
            FS_IDLE: begin
               if (!d_sync_q) begin
                  state_d   = FS_DATA;
                  bit_cnt_d = '0;
               end else begin
                  set_ferr = 1'b1;
               end
            end
            FS_DATA: begin
               shift_d = {d_sync_q, shift_q[7:1]};
               if (bit_cnt_q == 3'd7)
                  state_d = FS_PARITY;
               else
                  bit_cnt_d = bit_cnt_q + 3'd1;
            end
            FS_PARITY: begin
               par_ok_d = odd_parity_ok(shift_q, d_sync_q);
               state_d  = FS_STOP;
            end
            FS_STOP: begin
               state_d = FS_IDLE;
               if (!d_sync_q) begin
                  set_ferr   = 1'b1;
                  ext_pend_d = 1'b0;
                  brk_pend_d = 1'b0;
               end else if (!par_ok_q) begin
                  set_perr   = 1'b1;
                  ext_pend_d = 1'b0;
                  brk_pend_d = 1'b0;
               end else if (shift_q == CODE_EXT) begin
                  ext_pend_d = 1'b1;
               end else if (shift_q == CODE_BRK) begin
                  brk_pend_d = 1'b1;
               end else begin
                  wr_d           = 1'b1;
                  wr_word_d.ext  = ext_pend_q;
                  wr_word_d.brk  = brk_pend_q;
                  wr_word_d.code = shift_q;
                  ext_pend_d     = 1'b0;
                  brk_pend_d     = 1'b0;
               end
            end
            default: state_d = FS_IDLE;
         endcase
      end else if (state_q != FS_IDLE && to_cnt_q == TCW'(TIMEOUT_CYC - 1)) begin
         // Sender stalled mid-frame: abandon it.
         state_d    = FS_IDLE;
         to_cnt_d   = '0;
         ext_pend_d = 1'b0;
         brk_pend_d = 1'b0;
         set_ferr   = 1'b1;
      end

      // Sticky flags; a set in the same cycle wins over a clear.
      ovf_d  = fifo_ovf || (ovf_q  && !status_clr);
      perr_d = set_perr || (perr_q && !status_clr);
      ferr_d = set_ferr || (ferr_q && !status_clr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_meta_q   <= 1'b1;
         c_sync_q   <= 1'b1;
         d_meta_q   <= 1'b1;
         d_sync_q   <= 1'b1;
         filt_q     <= 1'b1;
         filt_cnt_q <= '0;
         smpl_en_q  <= 1'b0;
         state_q    <= FS_IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         par_ok_q   <= 1'b0;
         to_cnt_q   <= '0;
         ext_pend_q <= 1'b0;
         brk_pend_q <= 1'b0;
         wr_q       <= 1'b0;
         wr_word_q  <= '0;
         ovf_q      <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         c_meta_q   <= ps2_c;
         c_sync_q   <= c_meta_q;
         d_meta_q   <= ps2_d;
         d_sync_q   <= d_meta_q;
         filt_q     <= filt_d;
         filt_cnt_q <= filt_cnt_d;
         smpl_en_q  <= smpl_en_d;
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         par_ok_q   <= par_ok_d;
         to_cnt_q   <= to_cnt_d;
         ext_pend_q <= ext_pend_d;
         brk_pend_q <= brk_pend_d;
         wr_q       <= wr_d;
         wr_word_q  <= wr_word_d;
         ovf_q      <= ovf_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
      end
   end

   ps2_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (SCAN_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_q),
      .wr_data (SCAN_W'(wr_word_q)),
      .rd_en   (fifo_rd),
      .head    (fifo_head),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .ovf     (fifo_ovf)
   );

   always_comb begin
      status                                 = '0;
      status[STAT_EMPTY]                     = fifo_empty;
      status[STAT_FULL]                      = fifo_full;
      status[STAT_OVF]                       = ovf_q;
      status[STAT_PERR]                      = perr_q;
      status[STAT_FERR]                      = ferr_q;
      status[STAT_CNT_LSB +: STAT_CNT_W]     = STAT_CNT_W'(fifo_count);
   end

   assign data = 32'(fifo_head);

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: directed and randomized PS/2 frames against a queue-based model.
module tb_ps2_kbd_rx;
   import ps2_pkg::*;

   localparam int DEPTH = 16;
   localparam int FLEN  = 8;
   localparam int TOUT  = 2000;
   localparam int HALF  = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ps2_c = 1'b1;
   logic        ps2_d = 1'b1;
   logic        fifo_rd = 1'b0;
   logic        status_clr = 1'b0;
   logic [31:0] status, data;

   always #5 clk = ~clk;

   ps2_kbd_rx #(
      .FIFO_DEPTH  (DEPTH),
      .FILT_LEN    (FLEN),
      .TIMEOUT_CYC (TOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ps2_c      (ps2_c),
      .ps2_d      (ps2_d),
      .fifo_rd    (fifo_rd),
      .status_clr (status_clr),
      .status     (status),
      .data       (data)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model
   logic [9:0] mq[$];
   bit m_ext, m_brk, m_ovf, m_perr, m_ferr;

   function automatic void model_reset();
      mq.delete();
      m_ext = 0; m_brk = 0; m_ovf = 0; m_perr = 0; m_ferr = 0;
   endfunction

   function automatic void model_pop();
      if (mq.size() > 0) void'(mq.pop_front());
   endfunction

   function automatic void model_frame(logic [7:0] code, bit par_ok, bit stop_ok);
      if (!stop_ok) begin
         m_ferr = 1; m_ext = 0; m_brk = 0;
      end else if (!par_ok) begin
         m_perr = 1; m_ext = 0; m_brk = 0;
      end else if (code == 8'hE0) begin
         m_ext = 1;
      end else if (code == 8'hF0) begin
         m_brk = 1;
      end else begin
         if (mq.size() < DEPTH) mq.push_back({m_ext, m_brk, code});
         else m_ovf = 1;
         m_ext = 0; m_brk = 0;
      end
   endfunction

   function automatic logic [31:0] exp_status();
      return {16'h0, 8'(mq.size()), 3'b0, m_ferr, m_perr, m_ovf,
              mq.size() == DEPTH, mq.size() == 0};
   endfunction

   function automatic logic [31:0] exp_data();
      return (mq.size() > 0) ? 32'(mq[0]) : 32'h0;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check_val({tag, "/status"}, status, exp_status());
      check_val({tag, "/data"}, data, exp_data());
   endtask

   // One PS/2 bit: data set during the high phase, then a low phase.
   // pop_mode 1: pop pulse in the high phase; 2: pop in the same cycle as the FIFO write.
   task automatic ps2_bit(input logic b, input int pop_mode);
      bit done;
      done  = 0;
      ps2_d = b;
      if (pop_mode == 1) begin
         @(negedge clk) fifo_rd = 1'b1;
         @(negedge clk) fifo_rd = 1'b0;
         repeat (HALF - 2) @(negedge clk);
      end else begin
         repeat (HALF) @(negedge clk);
      end
      ps2_c = 1'b0;
      if (pop_mode == 2) begin
         for (int i = 0; i < HALF; i++) begin
            @(negedge clk);
            fifo_rd = 1'b0;
            if (!done && dut.wr_q) begin
               fifo_rd = 1'b1;
               done    = 1;
            end
         end
         if (fifo_rd) begin
            @(negedge clk);
            fifo_rd = 1'b0;
         end
         check_val("wr_sync", 32'(done), 32'h1);
      end else begin
         repeat (HALF) @(negedge clk);
      end
      ps2_c = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                             input int pop_mode);
      logic [10:0] bits;
      logic        par;
      int          pm;
      par  = (~^code) ^ bad_par;
      bits = {~bad_stop, par, code, 1'b0};
      for (int i = 0; i < 11; i++) begin
         pm = 0;
         if (pop_mode == 1 && i == 5) pm = 1;
         if (pop_mode == 2 && i == 10) pm = 2;
         ps2_bit(bits[i], pm);
      end
      ps2_d = 1'b1;
      repeat (HALF) @(negedge clk);
      if (pop_mode != 0) model_pop();
      model_frame(code, !bad_par, !bad_stop);
   endtask

   task automatic do_pop();
      @(negedge clk) fifo_rd = 1'b1;
      @(negedge clk) fifo_rd = 1'b0;
      model_pop();
   endtask

   task automatic do_clr();
      @(negedge clk) status_clr = 1'b1;
      @(negedge clk) status_clr = 1'b0;
      m_ovf = 0; m_perr = 0; m_ferr = 0;
   endtask

   initial begin
      logic [7:0]  code;
      logic [10:0] bits;
      int          r, pm;
      bit          wr_expected;

      model_reset();
      repeat (3) @(negedge clk);
      check_val("rst_status", status, 32'h0000_0001);
      check_val("rst_data", data, 32'h0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check_all("post_rst");

      // Single frame, then pop back to empty
      send_frame(8'h1C, 0, 0, 0);
      check_all("f1c");
      check_val("f1c_data", data, 32'h01C);
      do_pop();
      check_all("f1c_pop");

      // Prefix handling
      send_frame(8'hE0, 0, 0, 0);
      send_frame(8'hF0, 0, 0, 0);
      check_all("e0f0_nowrite");
      send_frame(8'h75, 0, 0, 0);
      check_val("e0f075", data, 32'h375);
      check_all("e0f075_all");
      do_pop();
      send_frame(8'hF0, 0, 0, 0);
      send_frame(8'h1C, 0, 0, 0);
      check_val("f01c", data, 32'h11C);
      do_pop();
      check_all("prefix_done");

      // Bad parity, then clear
      send_frame(8'h1C, 1, 0, 0);
      check_all("badpar");
      do_clr();
      check_all("badpar_clr");

      // Bad stop bit drops the frame and a pending prefix
      send_frame(8'hE0, 0, 0, 0);
      send_frame(8'h2A, 0, 1, 0);
      check_all("badstop");
      send_frame(8'h1C, 0, 0, 0);
      check_all("badstop_next");
      do_pop();
      do_clr();

      // Start bit of 1 while idle
      ps2_bit(1'b1, 0);
      repeat (HALF) @(negedge clk);
      m_ferr = 1;
      check_all("idle_one");
      do_clr();

      // Fill past full
      for (int c = 8'h16; c <= 8'h26; c++) send_frame(8'(c), 0, 0, 0);
      check_all("full");
      check_val("full_head", data, 32'h016);
      // Pop and write in the same cycle on a full FIFO
      send_frame(8'h30, 0, 0, 2);
      check_all("full_popwr");
      for (int i = 0; i < DEPTH; i++) begin
         do_pop();
         check_all("drain");
      end
      do_clr();
      // Pop and write in the same cycle on an empty FIFO
      send_frame(8'h31, 0, 0, 2);
      check_all("empty_popwr");
      do_pop();

      // Short glitch on ps2_c must not count as a bit
      @(negedge clk) ps2_c = 1'b0;
      repeat (3) @(negedge clk);
      ps2_c = 1'b1;
      repeat (HALF) @(negedge clk);
      check_all("glitch");
      send_frame(8'h1C, 0, 0, 0);
      check_all("glitch_next");
      do_pop();

      // Timeout after a partial frame, with a prefix pending
      send_frame(8'hE0, 0, 0, 0);
      bits = {1'b1, ~^8'h32, 8'h32, 1'b0};
      for (int i = 0; i < 5; i++) ps2_bit(bits[i], 0);
      ps2_d = 1'b1;
      repeat (TOUT / 2) @(negedge clk);
      check_all("to_early");
      repeat (TOUT / 2 + HALF) @(negedge clk);
      m_ferr = 1; m_ext = 0; m_brk = 0;
      check_all("timeout");
      check_val("to_state", 32'(dut.state_q), 32'(FS_IDLE));
      send_frame(8'h32, 0, 0, 0);
      check_val("to_next", data, 32'h032);
      do_pop();
      do_clr();

      // Reset in the middle of a frame
      send_frame(8'hE0, 0, 0, 0);
      send_frame(8'h44, 0, 0, 0);
      for (int i = 0; i < 4; i++) ps2_bit(bits[i], 0);
      @(negedge clk) rst = 1'b1;
      ps2_c = 1'b1; ps2_d = 1'b1;
      @(negedge clk);
      check_val("midrst_status", status, 32'h0000_0001);
      check_val("midrst_data", data, 32'h0);
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      send_frame(8'h32, 0, 0, 0);
      check_val("midrst_next", data, 32'h032);
      check_all("midrst_all");

      // Randomized traffic
      for (int n = 0; n < 30; n++) begin
         r    = $urandom_range(0, 9);
         code = 8'($urandom);
         if (r == 2) code = 8'hE0;
         if (r == 3) code = 8'hF0;
         wr_expected = (r > 1) && code != 8'hE0 && code != 8'hF0;
         pm = $urandom_range(0, 2);
         if (pm == 2 && !wr_expected) pm = 0;
         send_frame(code, r == 0, r == 1, pm);
         check_all("rand");
         if ($urandom_range(0, 3) == 0) begin
            do_pop();
            check_all("rand_pop");
         end
         if ($urandom_range(0, 5) == 0) begin
            do_clr();
            check_all("rand_clr");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
